// File: rtl/debug_pkg.sv
// Shared debug-bridge definitions: mode codes and responder FSM states.
package debug_pkg;

  // Mode codes carried on the bridge 'mode' bus.
  localparam logic [2:0] DBG_NOP      = 3'b000;
  localparam logic [2:0] DBG_RD_DMEM  = 3'b001;
  localparam logic [2:0] DBG_RD_RF    = 3'b010;
  localparam logic [2:0] DBG_WR_DMEM  = 3'b011;
  localparam logic [2:0] DBG_WR_RF    = 3'b100;
  localparam logic [2:0] DBG_RD_IMEM  = 3'b101;
  localparam logic [2:0] DBG_RD_PCREG = 3'b110;
  localparam logic [2:0] DBG_RSVD     = 3'b111;

  // Regfile index that selects the PC shadow register.
  localparam logic [31:0] DBG_PC_ADDR = 32'd32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StHold,
    StWrite
  } dbg_state_e;

  function automatic logic is_read_mode(input logic [2:0] m);
    return (m == DBG_RD_DMEM) || (m == DBG_RD_RF) || (m == DBG_RD_IMEM) || (m == DBG_RD_PCREG);
  endfunction

  function automatic logic is_write_mode(input logic [2:0] m);
    return (m == DBG_WR_DMEM) || (m == DBG_WR_RF);
  endfunction

endpackage

// File: rtl/debug_bridge_responder.sv
// Core-side end of the debug bridge: turns controller requests into single-cycle
// accesses on the halted core's dmem/imem/regfile debug ports.
module debug_bridge_responder
  import debug_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_flag,
  input  logic [2:0]  mode,
  input  logic [31:0] address_bridged,
  input  logic [31:0] data_bridged,
  output logic [31:0] data_internal,
  output logic        doneSending,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        imem_re,
  output logic        imem_we,
  output logic        rf_re,
  output logic        rf_we,
  input  logic [31:0] dmem_rdata,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] rf_rdata
);

  localparam logic [3:0] CntLoad = 4'(RD_LATENCY - 1);

  dbg_state_e  state_q, state_d;
  logic [2:0]  mode_q, mode_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        tx_flag_q, tx_flag_d;
  logic        misaligned;

  assign misaligned    = (addr_q[1:0] != 2'b00);
  assign data_internal = data_q;
  assign doneSending   = (state_q == StResp);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      mode_q    <= DBG_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b1;
      tx_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      tx_flag_q <= tx_flag_d;
    end
  end

  // Next-state logic: request decode, latency countdown, capture and re-arm.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    // Freeze the edge reference during WRITE so a read edge landing there survives.
    tx_flag_d = (state_q == StWrite) ? tx_flag_q : tx_flag;

    unique case (state_q)
      StIdle: begin
        if (mode == DBG_NOP) begin
          armed_d = 1'b1;
        end
        if (tx_flag && !tx_flag_q && is_read_mode(mode)) begin
          mode_d  = mode;
          addr_d  = address_bridged;
          state_d = StIssue;
        end else if (is_write_mode(mode) && armed_q) begin
          mode_d  = mode;
          addr_d  = address_bridged;
          wdata_d = data_bridged;
          state_d = StWrite;
        end
      end
      StIssue: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          case (mode_q)
            DBG_RD_DMEM:  data_d = misaligned ? 32'd0 : dmem_rdata;
            DBG_RD_IMEM:  data_d = misaligned ? 32'd0 : imem_rdata;
            DBG_RD_RF,
            DBG_RD_PCREG: data_d = rf_rdata;
            default:      data_d = 32'd0;
          endcase
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StHold;
      end
      StHold: begin
        if (!tx_flag) begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        armed_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Access strobes and address/data, decoded from registered state only.
  always_comb begin
    dbg_addr  = '0;
    dbg_wdata = '0;
    dmem_re   = 1'b0;
    dmem_we   = 1'b0;
    imem_re   = 1'b0;
    imem_we   = 1'b0;
    rf_re     = 1'b0;
    rf_we     = 1'b0;

    if (state_q == StIssue) begin
      case (mode_q)
        DBG_RD_DMEM: begin
          if (!misaligned) begin
            dmem_re  = 1'b1;
            dbg_addr = addr_q;
          end
        end
        DBG_RD_IMEM: begin
          if (!misaligned) begin
            imem_re  = 1'b1;
            dbg_addr = addr_q;
          end
        end
        DBG_RD_RF: begin
          rf_re    = 1'b1;
          dbg_addr = {27'd0, addr_q[4:0]};
        end
        DBG_RD_PCREG: begin
          rf_re    = 1'b1;
          dbg_addr = DBG_PC_ADDR;
        end
        default: ;
      endcase
    end else if (state_q == StWrite) begin
      case (mode_q)
        DBG_WR_DMEM: begin
          if (!misaligned) begin
            dmem_we   = 1'b1;
            dbg_addr  = addr_q;
            dbg_wdata = wdata_q;
          end
        end
        DBG_WR_RF: begin
          // x0 is hardwired; the write is swallowed but still disarms.
          if (addr_q[4:0] != 5'd0) begin
            rf_we     = 1'b1;
            dbg_addr  = {27'd0, addr_q[4:0]};
            dbg_wdata = wdata_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_bridge_responder.sv
// Directed bench for debug_bridge_responder: one instance at RD_LATENCY=1, one at 3.
module tb_debug_bridge_responder;
  import debug_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] address_bridged, data_bridged;
  logic [31:0] dmem_rdata, imem_rdata, rf_rdata;

  logic        tx1, tx3;
  logic [2:0]  mode1, mode3;
  logic [31:0] data1, addr1, wdata1, data3, addr3, wdata3;
  logic        done1, dre1, dwe1, ire1, iwe1, rre1, rwe1;
  logic        done3, dre3, dwe3, ire3, iwe3, rre3, rwe3;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 CLK = ~CLK;

  debug_bridge_responder #(.RD_LATENCY(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .tx_flag(tx1), .mode(mode1),
    .address_bridged(address_bridged), .data_bridged(data_bridged),
    .data_internal(data1), .doneSending(done1), .dbg_addr(addr1), .dbg_wdata(wdata1),
    .dmem_re(dre1), .dmem_we(dwe1), .imem_re(ire1), .imem_we(iwe1),
    .rf_re(rre1), .rf_we(rwe1),
    .dmem_rdata(dmem_rdata), .imem_rdata(imem_rdata), .rf_rdata(rf_rdata)
  );

  debug_bridge_responder #(.RD_LATENCY(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .tx_flag(tx3), .mode(mode3),
    .address_bridged(address_bridged), .data_bridged(data_bridged),
    .data_internal(data3), .doneSending(done3), .dbg_addr(addr3), .dbg_wdata(wdata3),
    .dmem_re(dre3), .dmem_we(dwe3), .imem_re(ire3), .imem_we(iwe3),
    .rf_re(rre3), .rf_we(rwe3),
    .dmem_rdata(dmem_rdata), .imem_rdata(imem_rdata), .rf_rdata(rf_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Strobes must be one-hot-or-zero every cycle out of reset.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      checks++;
      assert ($onehot0({dre1, dwe1, ire1, iwe1, rre1, rwe1}))
      else begin
        errors++;
        $error("FAIL excl1: observed %b expected onehot0", {dre1, dwe1, ire1, iwe1, rre1, rwe1});
      end
      checks++;
      assert ($onehot0({dre3, dwe3, ire3, iwe3, rre3, rwe3}))
      else begin
        errors++;
        $error("FAIL excl3: observed %b expected onehot0", {dre3, dwe3, ire3, iwe3, rre3, rwe3});
      end
    end
  end

  initial begin
    RST = 1'b1;
    tx1 = 1'b0; tx3 = 1'b0; mode1 = DBG_NOP; mode3 = DBG_NOP;
    address_bridged = '0; data_bridged = '0;
    dmem_rdata = 32'hCAFE_F00D; imem_rdata = 32'h1357_9BDF; rf_rdata = 32'h0BAD_F00D;
    step(); step();
    chk("rst_data", data1, 32'd0);
    chk("rst_strb", 32'({done1, dre1, dwe1, ire1, iwe1, rre1, rwe1}), 32'd0);
    chk("rst_addr", addr1 | wdata1, 32'd0);
    RST = 1'b0;
    step();

    // RD_DMEM at 0x100, latency 1.
    address_bridged = 32'h100; mode1 = DBG_RD_DMEM; tx1 = 1'b1;
    step();
    chk("dmem_re_issue", 32'(dre1), 32'd1);
    chk("dmem_addr", addr1, 32'h100);
    chk("done_early", 32'(done1), 32'd0);
    step();
    chk("dmem_re_once", 32'(dre1), 32'd0);
    chk("done_wait", 32'(done1), 32'd0);
    chk("data_pre", data1, 32'd0);
    step();
    chk("done_pulse", 32'(done1), 32'd1);
    chk("data_dmem", data1, 32'hCAFE_F00D);
    n = 0;
    repeat (10) begin
      step();
      if (dre1 || done1) n++;
    end
    chk("stuck_tx", n, 32'd0);
    tx1 = 1'b0; step(); step();

    // RD_PCREG selects regfile index 32.
    mode1 = DBG_RD_PCREG; tx1 = 1'b1;
    step();
    chk("pc_rf_re", 32'(rre1), 32'd1);
    chk("pc_addr", addr1, 32'd32);
    step(); step();
    chk("pc_done", 32'(done1), 32'd1);
    chk("pc_data", data1, 32'h0BAD_F00D);
    tx1 = 1'b0; step(); step();

    // Misaligned RD_IMEM at 0x102.
    address_bridged = 32'h102; mode1 = DBG_RD_IMEM; tx1 = 1'b1;
    step();
    chk("mis_imem_re", 32'(ire1), 32'd0);
    step(); step();
    chk("mis_done", 32'(done1), 32'd1);
    chk("mis_data", data1, 32'd0);
    tx1 = 1'b0; mode1 = DBG_NOP; step(); step();

    // WR_RF x5 <- 0x12345678, single pulse while mode is held.
    address_bridged = 32'd5; data_bridged = 32'h1234_5678; mode1 = DBG_WR_RF;
    step();
    chk("wr_rf_we", 32'(rwe1), 32'd1);
    chk("wr_addr", addr1, 32'd5);
    chk("wr_wdata", wdata1, 32'h1234_5678);
    n = 0;
    repeat (5) begin step(); if (rwe1) n++; end
    chk("wr_hold", n, 32'd0);
    mode1 = DBG_NOP; step();
    mode1 = DBG_WR_RF;
    n = 0;
    repeat (4) begin step(); if (rwe1) n++; end
    chk("wr_rearm", n, 32'd1);

    // WR_RF to x0 gives no strobe but disarms.
    mode1 = DBG_NOP; step();
    address_bridged = 32'd0; mode1 = DBG_WR_RF;
    n = 0;
    repeat (4) begin step(); if (rwe1) n++; end
    chk("wr_x0", n, 32'd0);
    address_bridged = 32'd5;
    n = 0;
    repeat (4) begin step(); if (rwe1) n++; end
    chk("wr_disarmed", n, 32'd0);
    mode1 = DBG_NOP; step();

    // Latency 3: RD_RF x31, mode switched to WR_DMEM during WAIT.
    address_bridged = 32'd31; mode3 = DBG_RD_RF; tx3 = 1'b1;
    step();
    chk("l3_rf_re", 32'(rre3), 32'd1);
    chk("l3_addr", addr3, 32'd31);
    mode3 = DBG_WR_DMEM;
    step();
    chk("l3_no_we", 32'(dwe3), 32'd0);
    step(); step();
    chk("l3_pre_cap", data3, 32'd0);
    chk("l3_pre_done", 32'(done3), 32'd0);
    step();
    chk("l3_done", 32'(done3), 32'd1);
    chk("l3_data", data3, 32'h0BAD_F00D);
    chk("l3_no_we2", 32'(dwe3), 32'd0);
    mode3 = DBG_NOP; tx3 = 1'b0; step(); step();

    // Reset during WAIT, then a clean read.
    address_bridged = 32'h100; mode3 = DBG_RD_DMEM; tx3 = 1'b1;
    step(); step();
    RST = 1'b1;
    #1;
    chk("rst_mid_data", data3, 32'd0);
    chk("rst_mid_strb", 32'({done3, dre3, dwe3, ire3, iwe3, rre3, rwe3}), 32'd0);
    chk("rst_mid_addr", addr3 | wdata3, 32'd0);
    tx3 = 1'b0; mode3 = DBG_NOP;
    step();
    RST = 1'b0;
    step();
    tx3 = 1'b1; mode3 = DBG_RD_DMEM;
    step();
    chk("post_rst_re", 32'(dre3), 32'd1);
    step(); step(); step(); step();
    chk("post_rst_done", 32'(done3), 32'd1);
    chk("post_rst_data", data3, 32'hCAFE_F00D);
    tx3 = 1'b0; mode3 = DBG_NOP; step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
